// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, widths
// and the branch-decision helper used by the next-PC logic.
package cpu_fetch_pkg;

    localparam int PC_W         = 64;
    localparam int INSTR_W      = 32;
    localparam int INSTR_BYTES  = 4;
    localparam int BRANCH_SHIFT = 2;
    localparam int TMO_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // A conditional branch is taken only on a zero result; unconditional always wins.
    function automatic logic branch_taken(input logic uncond, input logic cond, input logic zero);
        return uncond | (cond & zero);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC former: sequential step or PC-relative branch target,
// both computed as a silent modulo-2^64 add.
module fetch_next_pc
    import cpu_fetch_pkg::*;
(
    input  logic [PC_W-1:0] InstrPC,
    input  logic [PC_W-1:0] BusImm,
    input  logic            Uncondbranch,
    input  logic            Branch,
    input  logic            Zero,
    output logic [PC_W-1:0] next_pc
);

    logic            w_taken;
    logic [PC_W-1:0] w_offset;

    always_comb begin
        w_taken  = branch_taken(Uncondbranch, Branch, Zero);
        // BusImm counts instruction words, so the branch offset is scaled to bytes.
        w_offset = w_taken ? (BusImm << BRANCH_SHIFT) : PC_W'(INSTR_BYTES);
        next_pc  = InstrPC + w_offset;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, walks IDLE -> REQ -> HOLD over a req/ack memory
// handshake, presents each word to decode and faults if memory never answers.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               Reset_L,
    output logic               ImemReq,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic [PC_W-1:0]    InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic [PC_W-1:0]    BusImm,
    input  logic               Uncondbranch,
    input  logic               Branch,
    input  logic               Zero,
    output logic               FetchFault
);

    generate
        if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
            $error("instruction_fetch_unit: RESET_PC must be word aligned");
        end
        if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 255) begin : g_bad_timeout
            $error("instruction_fetch_unit: IMEM_TIMEOUT must be in 1..255");
        end
    endgenerate

    // Last count value that may still wait; a miss here exhausts the budget.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IMEM_TIMEOUT - 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic [TMO_W-1:0]   r_tmo_cnt;

    logic               w_capture;
    logic               w_pc_load;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic [PC_W-1:0]    w_next_pc;

    fetch_next_pc u_next_pc (
        .InstrPC      (r_instr_pc),
        .BusImm       (BusImm),
        .Uncondbranch (Uncondbranch),
        .Branch       (Branch),
        .Zero         (Zero),
        .next_pc      (w_next_pc)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_pc_load    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
                w_cnt_clr    = 1'b1;
            end
            ST_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (ImemAck) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (InstrReady) begin
                    w_pc_load    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_capture) begin
                r_instr    <= ImemData;
                r_instr_pc <= r_pc;
            end
            if (w_cnt_clr) begin
                r_tmo_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Status outputs decode straight from state so reset removes them at once.
    assign ImemReq     = (r_state == ST_REQ);
    assign InstrValid  = (r_state == ST_HOLD);
    assign FetchFault  = (r_state == ST_FAULT);
    assign ImemAddr    = r_pc;
    assign Instruction = r_instr;
    assign InstrPC     = r_instr_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a table of fetch transactions
// followed by timeout, sticky-fault and asynchronous-reset sequences.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        Reset_L;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instruction;
    logic [63:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [63:0] BusImm;
    logic        Uncondbranch;
    logic        Branch;
    logic        Zero;
    logic        FetchFault;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetch_unit #(.RESET_PC(64'h0), .IMEM_TIMEOUT(16)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .BusImm       (BusImm),
        .Uncondbranch (Uncondbranch),
        .Branch       (Branch),
        .Zero         (Zero),
        .FetchFault   (FetchFault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          delay;
        int          hold;
        logic        uncond;
        logic        branch;
        logic        zero;
        logic [63:0] imm;
        logic [63:0] next;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at a falling edge with the DUT expected to be in REQ.
    task automatic run_vec(input int idx, input vec_t v);
        check($sformatf("v%0d req", idx), 64'(ImemReq), 64'd1);
        check($sformatf("v%0d addr", idx), ImemAddr, v.addr);
        for (int d = 0; d < v.delay; d++) begin
            InstrReady   = 1'b1;
            Uncondbranch = 1'b1;
            BusImm       = 64'd5;
            ImemData     = 32'hDEADBEEF;
            @(negedge CLK);
            check($sformatf("v%0d wait addr", idx), ImemAddr, v.addr);
            check($sformatf("v%0d wait valid", idx), 64'(InstrValid), 64'd0);
        end
        InstrReady   = 1'b0;
        Uncondbranch = 1'b0;
        BusImm       = 64'd0;
        ImemAck      = 1'b1;
        ImemData     = v.data;
        @(negedge CLK);
        ImemAck  = 1'b0;
        ImemData = 32'h0;
        check($sformatf("v%0d valid", idx), 64'(InstrValid), 64'd1);
        check($sformatf("v%0d req low", idx), 64'(ImemReq), 64'd0);
        check($sformatf("v%0d instr", idx), 64'(Instruction), 64'(v.data));
        check($sformatf("v%0d instr_pc", idx), InstrPC, v.addr);
        for (int h = 0; h < v.hold; h++) begin
            ImemAck  = 1'b1;
            ImemData = 32'h0BADF00D;
            @(negedge CLK);
            check($sformatf("v%0d hold instr", idx), 64'(Instruction), 64'(v.data));
            check($sformatf("v%0d hold valid", idx), 64'(InstrValid), 64'd1);
        end
        ImemAck      = 1'b0;
        ImemData     = 32'h0;
        InstrReady   = 1'b1;
        Uncondbranch = v.uncond;
        Branch       = v.branch;
        Zero         = v.zero;
        BusImm       = v.imm;
        @(negedge CLK);
        InstrReady   = 1'b0;
        Uncondbranch = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        BusImm       = 64'd0;
        check($sformatf("v%0d valid drop", idx), 64'(InstrValid), 64'd0);
        check($sformatf("v%0d next req", idx), 64'(ImemReq), 64'd1);
        check($sformatf("v%0d next addr", idx), ImemAddr, v.next);
        check($sformatf("v%0d no fault", idx), 64'(FetchFault), 64'd0);
        $display("[TB] vec %0d pc=%h instr=%h next=%h", idx, v.addr, v.data, ImemAddr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"}, 64'(ImemReq), 64'd0);
        check({tag, " valid"}, 64'(InstrValid), 64'd0);
        check({tag, " instr"}, 64'(Instruction), 64'd0);
        check({tag, " instr_pc"}, InstrPC, 64'd0);
        check({tag, " fault"}, 64'(FetchFault), 64'd0);
    endtask

    initial begin
        //          addr                   data          dly hld unc br  z   imm                    next
        vecs[0]  = '{64'h0,                32'hF84003E9, 0,  0,  0,  0,  0,  64'h0,                 64'h4};
        vecs[1]  = '{64'h4,                32'h11111111, 1,  0,  0,  0,  0,  64'h0,                 64'h8};
        vecs[2]  = '{64'h8,                32'h22222222, 0,  1,  0,  1,  0,  64'h3,                 64'hC};
        vecs[3]  = '{64'hC,                32'h33333333, 2,  2,  1,  0,  0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8};
        vecs[4]  = '{64'h8,                32'h44444444, 0,  0,  0,  1,  1,  64'h3,                 64'h14};
        vecs[5]  = '{64'h14,               32'h55555555, 0,  0,  1,  1,  0,  64'hB,                 64'h40};
        vecs[6]  = '{64'h40,               32'h66666666, 3,  0,  1,  0,  0,  64'hFFFF_FFFF_FFFF_FFFE, 64'h38};
        vecs[7]  = '{64'h38,               32'h77777777, 0,  0,  1,  0,  0,  64'h0,                 64'h38};
        vecs[8]  = '{64'h38,               32'h88888888, 15, 0,  0,  0,  0,  64'h0,                 64'h3C};
        vecs[9]  = '{64'h3C,               32'h99999999, 0,  0,  0,  1,  1,  64'hFFFF_FFFF_FFFF_FFF1, 64'h0};
        vecs[10] = '{64'h0,                32'hAAAAAAAA, 0,  0,  1,  0,  0,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hBBBBBBBB, 0, 0, 0,  0,  1,  64'h7,                 64'h0};

        Reset_L      = 1'b0;
        ImemAck      = 1'b0;
        ImemData     = 32'h0;
        InstrReady   = 1'b0;
        BusImm       = 64'h0;
        Uncondbranch = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        check("reset addr", ImemAddr, 64'h0);
        Reset_L = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: 15 silent REQ cycles keep waiting, the 16th faults.
        repeat (15) @(negedge CLK);
        check("tmo still req", 64'(ImemReq), 64'd1);
        check("tmo no fault yet", 64'(FetchFault), 64'd0);
        @(negedge CLK);
        check("tmo fault", 64'(FetchFault), 64'd1);
        check("tmo req low", 64'(ImemReq), 64'd0);
        $display("[TB] timeout fault=%0d req=%0d", FetchFault, ImemReq);
        for (int c = 0; c < 50; c++) begin
            ImemAck    = c[0];
            ImemData   = 32'h12345678;
            InstrReady = 1'b1;
            @(negedge CLK);
            check("fault sticky", 64'({FetchFault, ImemReq, InstrValid}), 64'b100);
        end
        ImemAck    = 1'b0;
        InstrReady = 1'b0;
        #2 Reset_L = 1'b0;
        #1 check("fault cleared", 64'(FetchFault), 64'd0);
        check("fault rst req", 64'(ImemReq), 64'd0);
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
        check("refetch req", 64'(ImemReq), 64'd1);
        check("refetch addr", ImemAddr, 64'h0);
        $display("[TB] fault reset addr=%h", ImemAddr);

        // Reset in the middle of HOLD discards the live instruction.
        ImemAck  = 1'b1;
        ImemData = 32'hCAFE0001;
        @(negedge CLK);
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        @(negedge CLK);
        InstrReady = 1'b0;
        check("hr addr4", ImemAddr, 64'h4);
        ImemAck  = 1'b1;
        ImemData = 32'hCAFE0002;
        @(negedge CLK);
        ImemAck = 1'b0;
        check("hr hold valid", 64'(InstrValid), 64'd1);
        check("hr hold instr", 64'(Instruction), 64'hCAFE0002);
        #2 Reset_L = 1'b0;
        #1 check_reset_outputs("hold reset");
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
        check("hr refetch req", 64'(ImemReq), 64'd1);
        check("hr refetch addr", ImemAddr, 64'h0);
        check("hr refetch valid", 64'(InstrValid), 64'd0);
        $display("[TB] hold reset refetch addr=%h", ImemAddr);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
